// File: rtl/ldpc_dec_ibuf_ctrl.sv
// Write-side and flag controller for the ping-pong LLR input buffer.
// Optional frame checking (ieop / restart errors) with LDPC_DEC_IBUF_FRAME_CHECK_EN.
module ldpc_dec_ibuf_ctrl #(
    parameter int pADDR_W     = 8,
    parameter int pBLOCK_SIZE = 192,
    parameter int pTAG_W      = 4
) (
    input  logic               iclk,
    input  logic               ireset,
    input  logic               iclkena,
    input  logic               isop,
    input  logic               ival,
    input  logic               ieop,
    input  logic [pTAG_W-1:0]  itag,
    output logic               ordy,
    output logic               owrite,
    output logic [pADDR_W-1:0] owaddr,
    output logic               owbank,
    input  logic               ibuf_rempty,
    output logic               obuf_full,
    output logic               orbank,
    output logic [pTAG_W-1:0]  otag,
    output logic               oerr
);

    localparam logic [pADDR_W-1:0] cLAST = pADDR_W'(pBLOCK_SIZE - 1);

    typedef enum logic {IDLE, DATA} state_t;

    state_t              state;
    state_t              state_nxt;
    logic                wbank;
    logic [1:0]          full;
    logic [1:0]          full_nxt;
    logic [pADDR_W-1:0]  wcnt;
    logic [pADDR_W-1:0]  wcnt_nxt;
    logic [pADDR_W-1:0]  waddr;
    logic [pTAG_W-1:0]   tag_q [2];
    logic                acc;
    logic                take;
    logic                last;
    logic                close;
    logic                abort;
    logic                err;
    logic                rel;

    assign ordy = ~full[wbank];

    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        full_nxt  = full;
        acc       = ival & ordy & iclkena;
        // a word counts only inside a frame or when it opens one
        take      = acc & (isop | (state == DATA));
        waddr     = isop ? '0 : wcnt;
        last      = (waddr == cLAST);
        close     = take & last;
        abort     = 1'b0;
        err       = 1'b0;
        rel       = ibuf_rempty & obuf_full;
`ifdef LDPC_DEC_IBUF_FRAME_CHECK_EN
        abort     = take & ieop & ~last;
        err       = abort | (close & ~ieop) | (acc & isop & (state == DATA));
`endif
        if (take) begin
            if (close | abort) begin
                state_nxt = IDLE;
                wcnt_nxt  = '0;
            end else begin
                state_nxt = DATA;
                wcnt_nxt  = waddr + 1'b1;
            end
        end
        if (close) full_nxt[wbank] = 1'b1;
        if (rel)   full_nxt[orbank] = 1'b0;
    end

`ifndef LDPC_DEC_IBUF_FRAME_CHECK_EN
    logic unused_ieop;
    assign unused_ieop = ieop;
`endif

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            state <= IDLE;
        end else if (iclkena) begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            wcnt      <= '0;
            wbank     <= 1'b0;
            full      <= 2'b00;
            tag_q[0]  <= '0;
            tag_q[1]  <= '0;
            owrite    <= 1'b0;
            owaddr    <= '0;
            owbank    <= 1'b0;
            oerr      <= 1'b0;
            orbank    <= 1'b0;
            obuf_full <= 1'b0;
            otag      <= '0;
        end else if (iclkena) begin
            wcnt   <= wcnt_nxt;
            full   <= full_nxt;
            owrite <= take;
            owaddr <= waddr;
            owbank <= wbank;
            oerr   <= err;
            if (close) wbank <= ~wbank;
            if (take & isop) tag_q[wbank] <= itag;
            // full flag trails the RAM write by one cycle
            if (rel) begin
                orbank    <= ~orbank;
                obuf_full <= full[~orbank];
                otag      <= tag_q[~orbank];
            end else begin
                obuf_full <= full[orbank];
                otag      <= tag_q[orbank];
            end
        end
    end

endmodule

// File: tb/tb_ldpc_dec_ibuf_ctrl.sv
// Directed self-checking bench for ldpc_dec_ibuf_ctrl (block size 4).
// Expectations adapt to LDPC_DEC_IBUF_FRAME_CHECK_EN.
module tb_ldpc_dec_ibuf_ctrl;

    logic       iclk = 1'b0;
    logic       ireset = 1'b1;
    logic       iclkena = 1'b1;
    logic       isop = 1'b0;
    logic       ival = 1'b0;
    logic       ieop = 1'b0;
    logic [3:0] itag = '0;
    logic       ordy;
    logic       owrite;
    logic [7:0] owaddr;
    logic       owbank;
    logic       ibuf_rempty = 1'b0;
    logic       obuf_full;
    logic       orbank;
    logic [3:0] otag;
    logic       oerr;

    int total = 0;
    int bad = 0;

`ifdef LDPC_DEC_IBUF_FRAME_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    ldpc_dec_ibuf_ctrl #(
        .pADDR_W     (8),
        .pBLOCK_SIZE (4),
        .pTAG_W      (4)
    ) dut (
        .iclk        (iclk),
        .ireset      (ireset),
        .iclkena     (iclkena),
        .isop        (isop),
        .ival        (ival),
        .ieop        (ieop),
        .itag        (itag),
        .ordy        (ordy),
        .owrite      (owrite),
        .owaddr      (owaddr),
        .owbank      (owbank),
        .ibuf_rempty (ibuf_rempty),
        .obuf_full   (obuf_full),
        .orbank      (orbank),
        .otag        (otag),
        .oerr        (oerr)
    );

    always #5 iclk = ~iclk;

    task automatic tick();
        @(posedge iclk);
        #1;
    endtask

    task automatic drv(input logic v, input logic s, input logic e,
                       input logic [3:0] t);
        ival = v;
        isop = s;
        ieop = e;
        itag = t;
    endtask

    task automatic do_reset();
        drv(0, 0, 0, 0);
        ibuf_rempty = 1'b0;
        iclkena = 1'b1;
        ireset = 1'b1;
        tick();
        tick();
        ireset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({ordy, owrite, owaddr, owbank} !== {1'b1, 1'b0, 8'd0, 1'b0}) begin
            bad++;
            $display("FAIL reset_wr got %b/%b/%0d/%b exp 1/0/0/0",
                     ordy, owrite, owaddr, owbank);
        end
        total++;
        if ({obuf_full, orbank, otag, oerr} !== {1'b0, 1'b0, 4'd0, 1'b0}) begin
            bad++;
            $display("FAIL reset_rd got %b/%b/%0d/%b exp 0/0/0/0",
                     obuf_full, orbank, otag, oerr);
        end
    endtask

    task automatic test_single_frame();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drv(1, i == 0, i == 3, (i == 0) ? 4'd5 : 4'd0);
            tick();
            total++;
            if ({owrite, owaddr, owbank} !== {1'b1, 8'(i), 1'b0}) begin
                bad++;
                $display("FAIL single_wr%0d got %b/%0d/%b exp 1/%0d/0",
                         i, owrite, owaddr, owbank, i);
            end
        end
        drv(0, 0, 0, 0);
        total++;
        if (obuf_full !== 1'b0) begin
            bad++;
            $display("FAIL single_full_early got %b exp 0", obuf_full);
        end
        tick();
        total++;
        if ({obuf_full, otag, orbank, owrite} !== {1'b1, 4'd5, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL single_full got %b/%0d/%b/%b exp 1/5/0/0",
                     obuf_full, otag, orbank, owrite);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drv(1, (i % 4) == 0, (i % 4) == 3, (i < 4) ? 4'd3 : 4'd7);
            tick();
            total++;
            if ({owrite, owaddr, owbank} !== {1'b1, 8'(i % 4), 1'(i / 4)}) begin
                bad++;
                $display("FAIL b2b_wr%0d got %b/%0d/%b exp 1/%0d/%0d",
                         i, owrite, owaddr, owbank, i % 4, i / 4);
            end
        end
        total++;
        if ({ordy, obuf_full, otag, orbank} !== {1'b0, 1'b1, 4'd3, 1'b0}) begin
            bad++;
            $display("FAIL b2b_stall got %b/%b/%0d/%b exp 0/1/3/0",
                     ordy, obuf_full, otag, orbank);
        end
        drv(1, 1, 0, 4'd9);
        ibuf_rempty = 1'b1;
        tick();
        ibuf_rempty = 1'b0;
        total++;
        if ({owrite, ordy, orbank, otag, obuf_full} !==
            {1'b0, 1'b1, 1'b1, 4'd7, 1'b1}) begin
            bad++;
            $display("FAIL b2b_rel got %b/%b/%b/%0d/%b exp 0/1/1/7/1",
                     owrite, ordy, orbank, otag, obuf_full);
        end
        for (int i = 0; i < 4; i++) begin
            drv(1, i == 0, i == 3, (i == 0) ? 4'd9 : 4'd0);
            tick();
            total++;
            if ({owrite, owaddr, owbank} !== {1'b1, 8'(i), 1'b0}) begin
                bad++;
                $display("FAIL b2b_f3_wr%0d got %b/%0d/%b exp 1/%0d/0",
                         i, owrite, owaddr, owbank, i);
            end
        end
        drv(0, 0, 0, 0);
        tick();
        total++;
        if ({otag, orbank, obuf_full, ordy} !== {4'd7, 1'b1, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL b2b_hold got %0d/%b/%b/%b exp 7/1/1/0",
                     otag, orbank, obuf_full, ordy);
        end
    endtask

    task automatic test_rempty_idle();
        do_reset();
        drv(1, 0, 0, 4'd2);
        ibuf_rempty = 1'b1;
        tick();
        tick();
        ibuf_rempty = 1'b0;
        drv(0, 0, 0, 0);
        total++;
        if ({owrite, orbank, obuf_full, ordy} !== {1'b0, 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL rempty_idle got %b/%b/%b/%b exp 0/0/0/1",
                     owrite, orbank, obuf_full, ordy);
        end
    endtask

    task automatic test_restart();
        do_reset();
        drv(1, 1, 0, 4'd2);
        tick();
        drv(1, 0, 0, 4'd0);
        tick();
        drv(1, 1, 0, 4'd6);
        tick();
        total++;
        if ({owrite, owaddr, oerr} !== {1'b1, 8'd0, CHK}) begin
            bad++;
            $display("FAIL restart got %b/%0d/%b exp 1/0/%b",
                     owrite, owaddr, oerr, CHK);
        end
        for (int i = 1; i < 4; i++) begin
            drv(1, 0, i == 3, 4'd0);
            tick();
            total++;
            if ({owaddr, oerr} !== {8'(i), 1'b0}) begin
                bad++;
                $display("FAIL restart_wr%0d got %0d/%b exp %0d/0",
                         i, owaddr, oerr, i);
            end
        end
        drv(0, 0, 0, 0);
        tick();
        total++;
        if ({obuf_full, otag} !== {1'b1, 4'd6}) begin
            bad++;
            $display("FAIL restart_tag got %b/%0d exp 1/6", obuf_full, otag);
        end
    endtask

    task automatic test_short_frame();
        do_reset();
        drv(1, 1, 0, 4'd1);
        tick();
        drv(1, 0, 1, 4'd0);
        tick();
        total++;
        if ({owaddr, oerr} !== {8'd1, CHK}) begin
            bad++;
            $display("FAIL short_err got %0d/%b exp 1/%b", owaddr, oerr, CHK);
        end
        drv(0, 0, 0, 0);
        tick();
        tick();
        total++;
        if ({obuf_full, oerr} !== {1'b0, 1'b0}) begin
            bad++;
            $display("FAIL short_full got %b/%b exp 0/0", obuf_full, oerr);
        end
        for (int i = 0; i < 4; i++) begin
            drv(1, i == 0, i == 3, (i == 0) ? 4'd4 : 4'd0);
            tick();
            total++;
            if ({owaddr, owbank} !== {8'(i), 1'b0}) begin
                bad++;
                $display("FAIL short_next%0d got %0d/%b exp %0d/0",
                         i, owaddr, owbank, i);
            end
        end
        drv(0, 0, 0, 0);
        tick();
        total++;
        if ({obuf_full, otag, orbank} !== {1'b1, 4'd4, 1'b0}) begin
            bad++;
            $display("FAIL short_land got %b/%0d/%b exp 1/4/0",
                     obuf_full, otag, orbank);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drv(1, 1, 0, 4'd8);
        tick();
        drv(1, 0, 0, 4'd0);
        tick();
        drv(0, 0, 0, 0);
        ireset = 1'b1;
        #1;
        total++;
        if ({ordy, owrite, owaddr, owbank, obuf_full, otag} !==
            {1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 4'd0}) begin
            bad++;
            $display("FAIL rst_mid got %b/%b/%0d/%b/%b/%0d exp 1/0/0/0/0/0",
                     ordy, owrite, owaddr, owbank, obuf_full, otag);
        end
        tick();
        ireset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drv(1, i == 0, i == 3, (i == 0) ? 4'd11 : 4'd0);
            tick();
            total++;
            if ({owrite, owaddr, owbank} !== {1'b1, 8'(i), 1'b0}) begin
                bad++;
                $display("FAIL rst_mid_wr%0d got %b/%0d/%b exp 1/%0d/0",
                         i, owrite, owaddr, owbank, i);
            end
        end
        drv(0, 0, 0, 0);
        tick();
        total++;
        if ({obuf_full, otag} !== {1'b1, 4'd11}) begin
            bad++;
            $display("FAIL rst_mid_full got %b/%0d exp 1/11", obuf_full, otag);
        end
    endtask

    task automatic test_clkena();
        do_reset();
        drv(1, 1, 0, 4'd3);
        tick();
        drv(1, 0, 0, 4'd0);
        iclkena = 1'b0;
        tick();
        tick();
        total++;
        if ({owrite, owaddr} !== {1'b1, 8'd0}) begin
            bad++;
            $display("FAIL clkena_hold got %b/%0d exp 1/0", owrite, owaddr);
        end
        iclkena = 1'b1;
        tick();
        total++;
        if ({owrite, owaddr} !== {1'b1, 8'd1}) begin
            bad++;
            $display("FAIL clkena_run got %b/%0d exp 1/1", owrite, owaddr);
        end
        drv(0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_rempty_idle();
        test_restart();
        test_short_frame();
        test_reset_mid();
        test_clkena();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
